// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. Decodes the enable and
// clear pairs of the IF, ID and EX pipeline registers, the PC load enable and
// the PC source select from the current sequencer state and the hazard inputs.
// Event priority, highest first: memory wait-state, taken-branch flush,
// load-use stall, normal flow. Also keeps a sticky memory-timeout flag and a
// saturating count of cycles in which the PC was held.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..15)
//   MEM_TIMEOUT        consecutive mem_ready=0 cycles that set bus_err (1..65535)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   id_rs/id_rt  in   source register fields of the instruction in ID
//   id_uses_rt   in   ID instruction reads rt as a source
//   ex_mem_read  in   instruction in EX is a load
//   ex_waddr     in   destination register of the instruction in EX
//   br_taken     in   branch in MEM resolved taken
//   mem_ready    in   0 = memory inserting a wait-state
//   pc_en        out  PC load enable
//   pc_sel       out  0 = PC+4, 1 = branch target
//   if_en/if_clr out  IF register enable / synchronous clear
//   id_en/id_clr out  ID register enable / synchronous clear
//   ex_en/ex_clr out  EX register enable / synchronous clear
//   bus_err      out  sticky memory-timeout flag
//   stall_cnt    out  saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_waddr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        if_en,
    output logic        if_clr,
    output logic        id_en,
    output logic        id_clr,
    output logic        ex_en,
    output logic        ex_clr,
    output logic        bus_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // The first bubble is issued from RUN, so LSTALL covers the remaining
    // LOAD_STALL_CYCLES-1 bubbles: lcnt counts down to 0 inclusive.
    localparam logic        MULTI_STALL = (LOAD_STALL_CYCLES > 1) ? 1'b1 : 1'b0;
    localparam logic [3:0]  LCNT_INIT   = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam logic [15:0] TMO_LAST    = 16'(MEM_TIMEOUT - 1);

    state_t      state_r;
    state_t      ctx_r;
    logic [3:0]  lcnt_r;
    logic [15:0] tcnt_r;
    logic        bus_err_r;
    logic [31:0] stall_cnt_r;

    state_t      state_n_s;
    state_t      ctx_n_s;
    state_t      eff_s;
    logic [3:0]  lcnt_n_s;
    logic        lu_s;

    logic        pc_en_s;
    logic        pc_sel_s;
    logic        if_en_s;
    logic        if_clr_s;
    logic        id_en_s;
    logic        id_clr_s;
    logic        ex_en_s;
    logic        ex_clr_s;

    // Load-use hit: EX load writes a register the ID instruction reads (r0 never hazards).
    assign lu_s = ex_mem_read & (ex_waddr != 5'd0) &
                  ((ex_waddr == id_rs) | (id_uses_rt & (ex_waddr == id_rt)));

    // Effective context: leaving WAIT behaves exactly like the saved RUN/LSTALL state.
    always_comb begin
        if (state_r == WAIT) begin
            eff_s = ctx_r;
        end else begin
            eff_s = state_r;
        end
    end

    // Next-state and control decode, priority wait > flush > load-use > normal.
    always_comb begin
        pc_en_s   = 1'b1;
        pc_sel_s  = 1'b0;
        if_en_s   = 1'b1;
        if_clr_s  = 1'b0;
        id_en_s   = 1'b1;
        id_clr_s  = 1'b0;
        ex_en_s   = 1'b1;
        ex_clr_s  = 1'b0;
        state_n_s = RUN;
        ctx_n_s   = ctx_r;
        lcnt_n_s  = lcnt_r;

        if (!mem_ready) begin
            // Whole pipeline frozen; lcnt holds so the stall resumes where it left off.
            pc_en_s   = 1'b0;
            if_en_s   = 1'b0;
            id_en_s   = 1'b0;
            ex_en_s   = 1'b0;
            state_n_s = WAIT;
            if (state_r == WAIT) begin
                ctx_n_s = ctx_r;
            end else begin
                ctx_n_s = state_r;
            end
        end else if (br_taken) begin
            // Flush the three younger stages and redirect; any pending stall is dropped.
            pc_sel_s  = 1'b1;
            if_clr_s  = 1'b1;
            id_clr_s  = 1'b1;
            ex_clr_s  = 1'b1;
            state_n_s = RUN;
            ctx_n_s   = RUN;
            lcnt_n_s  = 4'd0;
        end else begin
            case (eff_s)
                RUN: begin
                    if (lu_s) begin
                        pc_en_s  = 1'b0;
                        if_en_s  = 1'b0;
                        id_clr_s = 1'b1;
                        if (MULTI_STALL) begin
                            state_n_s = LSTALL;
                            lcnt_n_s  = LCNT_INIT;
                        end else begin
                            state_n_s = RUN;
                            lcnt_n_s  = 4'd0;
                        end
                    end else begin
                        state_n_s = RUN;
                        lcnt_n_s  = lcnt_r;
                    end
                end
                LSTALL: begin
                    pc_en_s  = 1'b0;
                    if_en_s  = 1'b0;
                    id_clr_s = 1'b1;
                    if (lcnt_r == 4'd0) begin
                        state_n_s = RUN;
                        lcnt_n_s  = 4'd0;
                    end else begin
                        state_n_s = LSTALL;
                        lcnt_n_s  = lcnt_r - 4'd1;
                    end
                end
                default: begin
                    state_n_s = RUN;
                    lcnt_n_s  = 4'd0;
                end
            endcase
        end
    end

    // Sequencer state, saved wait context and load-stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            ctx_r   <= RUN;
            lcnt_r  <= 4'd0;
        end else begin
            state_r <= state_n_s;
            ctx_r   <= ctx_n_s;
            lcnt_r  <= lcnt_n_s;
        end
    end

    // Wait-state length counter (saturating) and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r    <= 16'd0;
            bus_err_r <= 1'b0;
        end else begin
            if (!mem_ready) begin
                if (tcnt_r != 16'hFFFF) begin
                    tcnt_r <= tcnt_r + 16'd1;
                end else begin
                    tcnt_r <= tcnt_r;
                end
            end else begin
                tcnt_r <= 16'd0;
            end
            if (!mem_ready && (tcnt_r >= TMO_LAST)) begin
                bus_err_r <= 1'b1;
            end else begin
                bus_err_r <= bus_err_r;
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (!pc_en_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign pc_en     = pc_en_s;
    assign pc_sel    = pc_sel_s;
    assign if_en     = if_en_s;
    assign if_clr    = if_clr_s;
    assign id_en     = id_en_s;
    assign id_clr    = id_clr_s;
    assign ex_en     = ex_en_s;
    assign ex_clr    = ex_clr_s;
    assign bus_err   = bus_err_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two instances share one stimulus stream: dut_a (1 bubble, timeout 255) and
// dut_b (3 bubbles, timeout 8). A behavioural model tracks "bubbles still
// owed", the current wait-run length, the error flag and the stall count for
// each instance; the driver pushes expected responses into per-instance
// queues and a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_waddr;
    logic       id_uses_rt, ex_mem_read, br_taken, mem_ready;

    logic a_pc_en, a_pc_sel, a_if_en, a_if_clr, a_id_en, a_id_clr, a_ex_en, a_ex_clr, a_bus_err;
    logic b_pc_en, b_pc_sel, b_if_en, b_if_clr, b_id_en, b_id_clr, b_ex_en, b_ex_clr, b_bus_err;
    logic [31:0] a_stall_cnt, b_stall_cnt;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr), .br_taken(br_taken), .mem_ready(mem_ready),
        .pc_en(a_pc_en), .pc_sel(a_pc_sel), .if_en(a_if_en), .if_clr(a_if_clr),
        .id_en(a_id_en), .id_clr(a_id_clr), .ex_en(a_ex_en), .ex_clr(a_ex_clr),
        .bus_err(a_bus_err), .stall_cnt(a_stall_cnt));

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr), .br_taken(br_taken), .mem_ready(mem_ready),
        .pc_en(b_pc_en), .pc_sel(b_pc_sel), .if_en(b_if_en), .if_clr(b_if_clr),
        .id_en(b_id_en), .id_clr(b_id_clr), .ex_en(b_ex_en), .ex_clr(b_ex_clr),
        .bus_err(b_bus_err), .stall_cnt(b_stall_cnt));

    // ctrl bit order: {pc_en, pc_sel, if_en, if_clr, id_en, id_clr, ex_en, ex_clr}
    localparam logic [7:0] C_FROZEN = 8'b0000_0000;
    localparam logic [7:0] C_FLUSH  = 8'b1111_1111;
    localparam logic [7:0] C_STALL  = 8'b0000_1110;
    localparam logic [7:0] C_NORMAL = 8'b1010_1010;

    typedef struct {
        logic [7:0]  ctrl;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance
    int          lsc[2]  = '{1, 3};
    int          mt[2]   = '{255, 8};
    int          rem[2];
    int          wrun[2];
    logic        err_m[2];
    logic [31:0] cnt_m[2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset(int k);
        rem[k]   = 0;
        wrun[k]  = 0;
        err_m[k] = 1'b0;
        cnt_m[k] = 32'd0;
    endfunction

    function automatic logic [7:0] exp_ctrl(int k, logic lu, logic br, logic rdy);
        if (!rdy)                 return C_FROZEN;
        if (br)                   return C_FLUSH;
        if (rem[k] > 0 || lu)     return C_STALL;
        return C_NORMAL;
    endfunction

    function automatic void model_update(int k, logic lu, logic br, logic rdy);
        logic [7:0] c;
        c = exp_ctrl(k, lu, br, rdy);
        if (!rdy) begin
            wrun[k]++;
            if (wrun[k] >= mt[k]) err_m[k] = 1'b1;
        end else begin
            wrun[k] = 0;
            if (br)              rem[k] = 0;
            else if (rem[k] > 0) rem[k] = rem[k] - 1;
            else if (lu)         rem[k] = lsc[k] - 1;
        end
        if (!c[7] && cnt_m[k] != 32'hFFFF_FFFF) cnt_m[k] = cnt_m[k] + 32'd1;
    endfunction

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mr, input logic [4:0] wa,
                        input logic br, input logic rdy);
        exp_t e;
        logic lu;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_mem_read = mr; ex_waddr = wa; br_taken = br; mem_ready = rdy;
        lu = mr && (wa != 5'd0) && ((wa == rs) || (uses && (wa == rt)));
        for (int k = 0; k < 2; k++) begin
            if (r) model_reset(k);
            e.ctrl = exp_ctrl(k, lu, br, rdy);
            e.err  = err_m[k];
            e.cnt  = cnt_m[k];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < 2; k++) model_update(k, lu, br, rdy);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    // Monitor: compares every presented output set against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("a_ctrl", {24'd0, a_pc_en, a_pc_sel, a_if_en, a_if_clr, a_id_en, a_id_clr, a_ex_en, a_ex_clr}, {24'd0, e.ctrl});
            check("a_bus_err", {31'd0, a_bus_err}, {31'd0, e.err});
            check("a_stall_cnt", a_stall_cnt, e.cnt);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("b_ctrl", {24'd0, b_pc_en, b_pc_sel, b_if_en, b_if_clr, b_id_en, b_id_clr, b_ex_en, b_ex_clr}, {24'd0, e.ctrl});
            check("b_bus_err", {31'd0, b_bus_err}, {31'd0, e.err});
            check("b_stall_cnt", b_stall_cnt, e.cnt);
        end
    end

    // Hang guard
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int burst;
        logic r, u, m, b, rd;
        logic [4:0] rs, rt, wa;
        rst = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_waddr = 5'd0; br_taken = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        @(posedge clk); #1;

        // Reset then normal flow
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(3);
        // Load-use on rs, then the same with r0 as destination
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        idle(2);
        // rt hit with and without id_uses_rt
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
        idle(2);
        // Branch beats load-use in the same cycle
        step(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1);
        idle(2);
        // Branch in 2nd cycle of a multi-cycle stall
        step(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        idle(3);
        // Memory wait inside a stall, with a branch held across the wait
        step(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(4);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        idle(2);
        // Timeout: 10 wait cycles, sticky after ready, cleared by reset
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);
        // Reset in the middle of a stall and of a wait
        step(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic
        burst = 0;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            wa = 5'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            m  = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 9) == 0);
            if (burst > 0) begin
                rd = 1'b0;
                burst--;
            end else if ($urandom_range(0, 14) == 0) begin
                rd = 1'b0;
                burst = int'($urandom_range(0, 11));
            end else begin
                rd = 1'b1;
            end
            step(r, rs, rt, u, m, wa, b, rd);
        end
        idle(2);

        repeat (2) @(negedge clk);
        #1;
        check("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Generates the En/Clr pairs for the IF, ID and EX pipeline registers, plus PC enable and PC source select.
- Handles three events: load-use hazards against the instruction in EX, taken branches resolved in MEM, and memory wait-states.
- Also keeps a memory-timeout watchdog and a stall-cycle performance counter.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15.
- MEM_TIMEOUT, 255, consecutive mem_ready=0 cycles that set bus_err; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  1 = ID instruction reads rt as a source.
- ex_mem_read  in  1  1 = instruction in EX is a load.
- ex_waddr  in  5  destination register of the instruction in EX.
- br_taken  in  1  branch in MEM resolved taken.
- mem_ready  in  1  0 = data/instruction memory inserting a wait-state.
- pc_en  out  1  PC load enable.
- pc_sel  out  1  0 = PC+4, 1 = branch target.
- if_en  out  1  IF register enable.
- if_clr  out  1  IF register synchronous clear.
- id_en  out  1  ID register enable.
- id_clr  out  1  ID register synchronous clear.
- ex_en  out  1  EX register enable.
- ex_clr  out  1  EX register synchronous clear.
- bus_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  32  count of cycles with pc_en=0.

Behaviour:
- State register: RUN, LSTALL, WAIT. Internal counters: lcnt (4 bit), tcnt (16 bit).
- Reset (async, rst=1):
  - state=RUN, lcnt=0, tcnt=0, bus_err=0, stall_cnt=0.
  - Control outputs decode combinationally from state and inputs as below.
- Control outputs are combinational from state plus inputs, so hazards act in the same cycle. Only state, counters, bus_err and stall_cnt are registered.
- Hazard hit: lu = ex_mem_read & (ex_waddr!=0) & ((ex_waddr==id_rs) | (id_uses_rt & ex_waddr==id_rt)).
- Priority, highest first: mem wait > branch flush > load-use/LSTALL > normal.
- Mem wait (mem_ready=0, any state):
  - All en=0, all clr=0, pc_en=0, pc_sel=0.
  - Next state WAIT; state resumes to the saved RUN/LSTALL context when mem_ready=1.
  - lcnt does not decrement while frozen.
  - tcnt increments each wait cycle, saturating. On tcnt reaching MEM_TIMEOUT-1 with mem_ready still 0, bus_err<=1 and stays 1 until reset.
  - tcnt clears on the first cycle mem_ready=1.
- Branch flush (mem_ready=1, br_taken=1):
  - pc_en=1, pc_sel=1, if_clr=id_clr=ex_clr=1, all en=1.
  - Next state RUN, lcnt<=0; a pending load stall is aborted.
  - Lasts exactly one cycle; no state needed.
- Load-use (mem_ready=1, br_taken=0, state RUN and lu=1, or state LSTALL):
  - pc_en=0, if_en=0, id_en=1, id_clr=1 (bubble into ID register), ex_en=1, all other clr=0.
  - From RUN on lu: if LOAD_STALL_CYCLES>1, state<=LSTALL and lcnt<=LOAD_STALL_CYCLES-2; otherwise stay in RUN.
  - In LSTALL: if lcnt==0, state<=RUN; else lcnt decrements.
- Normal: all en=1, all clr=0, pc_en=1, pc_sel=0.
- stall_cnt increments on every rising edge where pc_en=0 (rst low); saturates at 0xFFFFFFFF, no wrap.
- br_taken with mem_ready=0: ignored (frozen); it takes effect on the first ready cycle because the MEM stage holds it.
- rst asserted mid-LSTALL or mid-WAIT: state returns to RUN immediately; the pending stall is discarded.

Test Plan:
- Reset, then normal flow: rst pulse, all hazard inputs 0, mem_ready=1 → pc_en=if_en=id_en=ex_en=1, all clr=0, stall_cnt=0, bus_err=0.
- Load-use on rs: ex_mem_read=1, ex_waddr=5, id_rs=5 for one cycle (LOAD_STALL_CYCLES=1) → that cycle pc_en=0, if_en=0, id_clr=1. Next cycle normal; stall_cnt=1. Repeat with ex_waddr=0 → no stall.
- Multi-cycle stall: LOAD_STALL_CYCLES=3, rt hit with id_uses_rt=1, inputs cleared after one cycle → exactly 3 consecutive stall cycles, stall_cnt=3. Same with id_uses_rt=0 → 0 stalls.
- Branch beats load-use: lu=1 and br_taken=1 in the same cycle → pc_sel=1, if_clr=id_clr=ex_clr=1, pc_en=1, no stall. Branch in the 2nd cycle of a 3-cycle LSTALL → flush, then RUN.
- Memory wait: mem_ready=0 for 4 cycles during LSTALL (lcnt=1) → 4 frozen cycles (all en=0), then the remaining 2 stall cycles. stall_cnt increments on all 6 cycles.
- Timeout: MEM_TIMEOUT=8, mem_ready=0 held 10 cycles → bus_err rises after the 8th wait cycle, stays 1 after mem_ready=1, clears only on rst.
